isa_cycle_sequencer: RTL and testbench

//  Runs one ISA I/O or memory bus cycle per command word from the host-side address/data/control registers.

---
 rtl/isa_seq_pkg.sv | 37 +++
 rtl/isa_sync2.sv | 22 ++
 rtl/isa_cycle_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_isa_cycle_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_seq_pkg.sv
// Shared types and default timing for the ISA bus cycle sequencer.
// The timeout feature itself is selected in the top by ISA_TIMEOUT_EN.
package isa_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_IOR,
        SEL_IOW,
        SEL_MEMR,
        SEL_MEMW
    } strobe_sel_t;

    localparam int DEF_SETUP_CYCLES   = 2;
    localparam int DEF_STROBE_CYCLES  = 8;
    localparam int DEF_HOLD_CYCLES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_CNT_W          = 11;

    function automatic strobe_sel_t strobe_sel(input logic rd, input logic mem);
        strobe_sel_t sel;
        case ({mem, rd})
            2'b00:   sel = SEL_IOW;
            2'b01:   sel = SEL_IOR;
            2'b10:   sel = SEL_MEMW;
            default: sel = SEL_MEMR;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchroniser for the asynchronous IOCHRDY input.
// Resets to 1 so a bus with nothing attached reads as ready.
module isa_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/isa_cycle_sequencer.sv
// Runs one ISA I/O or memory cycle per start pulse with programmable setup/strobe/hold timing.
// Define ISA_TIMEOUT_EN to abort IOCHRDY waits after TIMEOUT_CYCLES and flag error.
//
// state  | meaning
// IDLE   | waiting for start, bus idle
// SETUP  | address (and write data) driven, BALE high except last cycle
// STROBE | one command strobe low, extended while synced IOCHRDY is low
// HOLD   | strobes released, address/write data held
// DONE   | one-cycle done pulse, SD released
module isa_cycle_sequencer
    import isa_seq_pkg::*;
#(
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cmd_read,
    input  logic        cmd_mem,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] rdata,
    output logic [15:0] isa_sa,
    output logic [15:0] isa_sd_out,
    output logic        isa_sd_oe,
    input  logic [15:0] isa_sd_in,
    output logic        isa_bale,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    output logic        isa_memr_n,
    output logic        isa_memw_n,
    input  logic        isa_iochrdy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, mem_q;
    logic             rdy_s;
    logic             accept;
    logic             rd_next;
    logic             strobe_on;
    logic             drive_phase;
    logic             timeout;
    strobe_sel_t      sel;

    isa_sync2 u_sync_rdy (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (isa_iochrdy),
        .q       (rdy_s)
    );

    assign accept      = (state_q == IDLE) && start;
    assign rd_next     = accept ? cmd_read : rd_q;
    assign sel         = strobe_sel(rd_q, mem_q);
    assign strobe_on   = (state_d == STROBE);
    assign drive_phase = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = CNT_W'(STROBE_CYCLES - 1);
                end
            end
            STROBE: begin
                // minimum width elapsed; release on ready or on wait abort
                if ((cnt_q == '0) && (rdy_s || timeout)) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            mem_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            isa_sa     <= '0;
            isa_sd_out <= '0;
            isa_sd_oe  <= 1'b0;
            isa_bale   <= 1'b0;
            isa_ior_n  <= 1'b1;
            isa_iow_n  <= 1'b1;
            isa_memr_n <= 1'b1;
            isa_memw_n <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q   <= cmd_read;
                mem_q  <= cmd_mem;
                isa_sa <= cmd_addr;
                if (!cmd_read) begin
                    isa_sd_out <= cmd_wdata;
                end
            end
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
            isa_bale   <= (state_d == SETUP) && (cnt_d != '0);
            isa_sd_oe  <= drive_phase && !rd_next;
            isa_ior_n  <= !(strobe_on && (sel == SEL_IOR));
            isa_iow_n  <= !(strobe_on && (sel == SEL_IOW));
            isa_memr_n <= !(strobe_on && (sel == SEL_MEMR));
            isa_memw_n <= !(strobe_on && (sel == SEL_MEMW));
            if ((state_q == STROBE) && (state_d == HOLD) && rd_q && !timeout) begin
                rdata <= isa_sd_in;
            end
        end
    end

`ifdef ISA_TIMEOUT_EN
    logic [CNT_W-1:0] wait_q;
    logic             error_q;

    assign timeout = (state_q == STROBE) && (cnt_q == '0) && !rdy_s && (wait_q == '0);
    assign error   = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if ((state_d == STROBE) && (state_q != STROBE)) begin
                wait_q <= CNT_W'(TIMEOUT_CYCLES);
            end else if ((state_q == STROBE) && (cnt_q == '0) && !rdy_s && (wait_q != '0)) begin
                wait_q <= wait_q - CNT_W'(1);
            end
            if (accept) begin
                error_q <= 1'b0;
            end else if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign error          = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Scoreboard bench for isa_cycle_sequencer: expectations queued at start, checked at each done pulse.
// Build with ISA_TIMEOUT_EN to add the stuck-IOCHRDY abort case.
module tb_isa_cycle_sequencer;

    localparam int SETUP  = 2;
    localparam int STROBE = 8;
    localparam int HOLD   = 2;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cmd_read = 1'b0;
    logic        cmd_mem = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [15:0] isa_sd_in = '0;
    logic        isa_iochrdy = 1'b1;
    logic        busy, done, error;
    logic [15:0] rdata, isa_sa, isa_sd_out;
    logic        isa_sd_oe, isa_bale;
    logic        isa_ior_n, isa_iow_n, isa_memr_n, isa_memw_n;

    isa_cycle_sequencer #(
        .SETUP_CYCLES   (SETUP),
        .STROBE_CYCLES  (STROBE),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (11)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cmd_read    (cmd_read),
        .cmd_mem     (cmd_mem),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rdata       (rdata),
        .isa_sa      (isa_sa),
        .isa_sd_out  (isa_sd_out),
        .isa_sd_oe   (isa_sd_oe),
        .isa_sd_in   (isa_sd_in),
        .isa_bale    (isa_bale),
        .isa_ior_n   (isa_ior_n),
        .isa_iow_n   (isa_iow_n),
        .isa_memr_n  (isa_memr_n),
        .isa_memw_n  (isa_memw_n),
        .isa_iochrdy (isa_iochrdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          width;
        logic        err;
        int          oe_cycles;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_total = 0;
    int          accepted = 0;
    logic [15:0] model_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // per-transaction observations, reset at each done pulse
    int          low_cnt = 0;
    int          oe_cnt = 0;
    int          bale_cnt = 0;
    logic [3:0]  low_mask = '0;
    logic [3:0]  cur_low;
    logic [15:0] sa_at_strobe = '0;
    logic [15:0] sd_last_oe = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            low_cnt  = 0;
            oe_cnt   = 0;
            bale_cnt = 0;
            low_mask = '0;
        end else begin
            cur_low = {~isa_memw_n, ~isa_memr_n, ~isa_iow_n, ~isa_ior_n};
            if (cur_low != 4'b0000) begin
                low_cnt++;
                low_mask     = low_mask | cur_low;
                sa_at_strobe = isa_sa;
            end
            if (isa_sd_oe) begin
                oe_cnt++;
                sd_last_oe = isa_sd_out;
            end
            if (isa_bale) bale_cnt++;
            if (done) begin
                done_total++;
                check_eq("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    check_eq("strobe_sel", low_mask, e_mon.mask);
                    check_eq("strobe_width", low_cnt, e_mon.width);
                    check_eq("sa", sa_at_strobe, e_mon.addr);
                    check_eq("rdata", rdata, e_mon.rdata);
                    check_eq("error", error, e_mon.err);
                    check_eq("sd_oe_cycles", oe_cnt, e_mon.oe_cycles);
                    check_eq("bale_cycles", bale_cnt, SETUP - 1);
                    check_eq("latency", cyc - e_mon.start_cyc, 1 + SETUP + e_mon.width + HOLD);
                    if (e_mon.oe_cycles != 0) check_eq("sd_hold", sd_last_oe, e_mon.wdata);
                end
                low_cnt  = 0;
                oe_cnt   = 0;
                bale_cnt = 0;
                low_mask = '0;
            end
        end
    end

    task automatic issue(input logic rd, input logic mem, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] bus,
                         input int width, input logic err_exp);
        exp_t e;
        if (rd && !err_exp) model_rdata = bus;
        e.mask      = rd ? (mem ? 4'b0100 : 4'b0001) : (mem ? 4'b1000 : 4'b0010);
        e.addr      = addr;
        e.wdata     = wdata;
        e.rdata     = model_rdata;
        e.width     = width;
        e.err       = err_exp;
        e.oe_cycles = rd ? 0 : SETUP + width + HOLD;
        @(negedge clk);
        isa_sd_in = bus;
        cmd_read  = rd;
        cmd_mem   = mem;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        start     = 1'b1;
        e.start_cyc = cyc;
        sb.push_back(e);
        accepted++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check_eq("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_strobe(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ({isa_memw_n, isa_memr_n, isa_iow_n, isa_ior_n} != 4'hF) seen = 1;
        end
        check_eq("strobe_seen", 32'(seen), 1);
    endtask

    logic        r_rd, r_mem;
    logic [15:0] r_addr, r_data, r_bus;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_sa", isa_sa, 0);
        check_eq("rst_sd_out", isa_sd_out, 0);
        check_eq("rst_sd_oe", isa_sd_oe, 0);
        check_eq("rst_bale", isa_bale, 0);
        check_eq("rst_strobes", {isa_memw_n, isa_memr_n, isa_iow_n, isa_ior_n}, 4'hF);
        reset_n = 1'b1;

        issue(1'b0, 1'b0, 16'h0220, 16'h00AB, 16'h0000, STROBE, 1'b0);
        check_eq("busy_after_start", busy, 1);
        wait_done(40);
        issue(1'b1, 1'b0, 16'h022A, 16'h0000, 16'h00AA, STROBE, 1'b0);
        wait_done(40);
        issue(1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, STROBE, 1'b0);
        wait_done(40);
        issue(1'b1, 1'b1, 16'hC000, 16'h0000, 16'h3C3C, STROBE, 1'b0);
        wait_done(40);

        // IOCHRDY low from strobe cycle 5 for 20 cycles: strobe lasts 5+20+2
        issue(1'b1, 1'b1, 16'hA5A0, 16'h0000, 16'h9A5F, 5 + 20 + 2, 1'b0);
        wait_strobe(20);
        repeat (4) @(negedge clk);
        isa_iochrdy = 1'b0;
        repeat (20) @(negedge clk);
        isa_iochrdy = 1'b1;
        wait_done(60);

        // start while busy is dropped; start right after done is taken
        issue(1'b0, 1'b1, 16'h4000, 16'h0F0F, 16'h0000, STROBE, 1'b0);
        repeat (4) @(negedge clk);
        cmd_read = 1'b1;
        cmd_mem  = 1'b0;
        cmd_addr = 16'hDEAD;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        issue(1'b1, 1'b0, 16'h0061, 16'h0000, 16'h7E81, STROBE, 1'b0);
        wait_done(40);

`ifdef ISA_TIMEOUT_EN
        isa_iochrdy = 1'b0;
        issue(1'b1, 1'b1, 16'h8000, 16'h0000, 16'h5555, STROBE + TMO, 1'b1);
        wait_done(80);
        isa_iochrdy = 1'b1;
        @(negedge clk);
        check_eq("error_sticky", error, 1);
        issue(1'b1, 1'b0, 16'h0378, 16'h0000, 16'h1357, STROBE, 1'b0);
        check_eq("error_cleared", error, 0);
        wait_done(40);
`endif

        for (int i = 0; i < 4; i++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_mem  = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom);
            r_data = 16'($urandom);
            r_bus  = 16'($urandom);
            issue(r_rd, r_mem, r_addr, r_data, r_bus, STROBE, 1'b0);
            wait_done(40);
        end

        // reset in the middle of a write strobe
        issue(1'b0, 1'b0, 16'h0300, 16'h1234, 16'h0000, STROBE, 1'b0);
        wait_strobe(20);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_iow", isa_iow_n, 1);
        check_eq("rst_mid_sd_oe", isa_sd_oe, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        sb.delete();
        accepted--;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        issue(1'b1, 1'b0, 16'h0311, 16'h0000, 16'h4242, STROBE, 1'b0);
        wait_done(40);

        repeat (5) @(negedge clk);
        check_eq("done_count", done_total, accepted);
        check_eq("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
